// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - single-MAC sequencer for one fully-connected layer
//
// Evaluates out[o] = min(sum_i in[i]*w[o*N_IN+i] + b[o], 2^DW-1) for every
// neuron o. One multiplier-accumulator is shared across all products.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start, abort      begin a layer evaluation / cancel the one in progress
//   busy, done        evaluation in progress / one-cycle completion pulse
//   in_addr, in_data  input-vector read port (data one cycle after address)
//   w_addr, w_data    weight read port (data one cycle after address)
//   b_addr, b_data    bias read port (data one cycle after address)
//   out_we, out_addr, out_data  result write port, one write per neuron
module fc_layer_sequencer #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 10,
    parameter int DW    = 8,
    parameter int ACC_W = 2 * DW + $clog2(N_IN) + 1,
    localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic [WW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic [OW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          out_we,
    output logic [OW-1:0] out_addr,
    output logic [DW-1:0] out_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [IW-1:0]  I_LAST  = IW'(N_IN - 1);
    localparam logic [OW-1:0]  O_LAST  = OW'(N_OUT - 1);
    localparam logic [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << DW) - 1);

    state_t            state;
    logic [IW-1:0]     i;
    logic [OW-1:0]     o;
    logic [ACC_W-1:0]  acc;
    logic [DW-1:0]     bias;
    // prod_pend: a read was issued last cycle, so in_data/w_data are valid now.
    // bias_pend: that read was the i=0 issue, so b_data is valid now.
    logic              prod_pend;
    logic              bias_pend;

    logic [2*DW-1:0]   prod;
    logic [ACC_W-1:0]  acc_sum;
    logic [DW-1:0]     bias_eff;
    logic [ACC_W:0]    final_sum;
    logic [DW-1:0]     sat_val;

    always_comb begin
        prod      = in_data * w_data;
        acc_sum   = acc + ACC_W'(prod);
        // With N_IN=1 the bias arrives in the DRAIN cycle itself, so take it
        // straight from the read port instead of the latch.
        bias_eff  = bias_pend ? b_data : bias;
        final_sum = {1'b0, acc_sum} + (ACC_W + 1)'(bias_eff);
        sat_val   = (final_sum > SAT_MAX) ? {DW{1'b1}} : final_sum[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            i         <= '0;
            o         <= '0;
            acc       <= '0;
            bias      <= '0;
            prod_pend <= 1'b0;
            bias_pend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_we    <= 1'b0;
            done      <= 1'b0;
            prod_pend <= 1'b0;
            bias_pend <= 1'b0;

            // Absorb the product of the previous cycle's read.
            if (prod_pend) begin
                acc <= acc_sum;
            end
            if (bias_pend) begin
                bias <= b_data;
            end

            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= FETCH;
                            busy    <= 1'b1;
                            i       <= '0;
                            o       <= '0;
                            acc     <= '0;
                            in_addr <= '0;
                            w_addr  <= '0;
                            b_addr  <= '0;
                        end
                    end

                    FETCH: begin
                        // The address registers already hold this cycle's
                        // issue; prepare the next one. w_addr runs linearly
                        // across the whole layer, so its last increment of a
                        // neuron is already the next neuron's base.
                        prod_pend <= 1'b1;
                        bias_pend <= (i == '0);
                        w_addr    <= w_addr + WW'(1);
                        if (i == I_LAST) begin
                            state <= DRAIN;
                        end else begin
                            i       <= i + IW'(1);
                            in_addr <= i + IW'(1);
                        end
                    end

                    DRAIN: begin
                        state    <= WRITE;
                        out_we   <= 1'b1;
                        out_addr <= o;
                        out_data <= sat_val;
                    end

                    WRITE: begin
                        if (o == O_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            o       <= o + OW'(1);
                            i       <= '0;
                            acc     <= '0;
                            in_addr <= '0;
                            b_addr  <= o + OW'(1);
                        end
                    end

                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - self-checking bench for fc_layer_sequencer
module tb_fc_layer_sequencer;

    localparam int N_IN  = 10;
    localparam int N_OUT = 10;
    localparam int DW    = 8;
    localparam int PER   = N_IN + 2;
    localparam int TOT   = N_OUT * PER;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] in_addr;
    logic [7:0] in_data;
    logic [6:0] w_addr;
    logic [7:0] w_data;
    logic [3:0] b_addr;
    logic [7:0] b_data;
    logic       out_we;
    logic [3:0] out_addr;
    logic [7:0] out_data;

    fc_layer_sequencer dut (
        .clk     (clk),
        .reset   (rst_n),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .in_addr (in_addr),
        .in_data (in_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .out_we  (out_we),
        .out_addr(out_addr),
        .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data appears one cycle after the address.
    logic [7:0] in_mem [16];
    logic [7:0] w_mem  [128];
    logic [7:0] b_mem  [16];
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_out [N_OUT];
    int got     [N_OUT];
    int nwr   = 0;
    int ndone = 0;
    int run_start = 0;
    bit live = 0;
    bit checking = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: out[o] from plain arithmetic over the memories.
    task automatic compute_model();
        for (int o = 0; o < N_OUT; o++) begin
            int s;
            s = b_mem[o];
            for (int k = 0; k < N_IN; k++) s += in_mem[k] * w_mem[o * N_IN + k];
            exp_out[o] = (s > 255) ? 255 : s;
        end
    endtask

    // set 0: inputs 9-i, w[k]=k, b[o]=o ; 1: all ones, bias 0 ; 2: w=0, b[o]=o
    task automatic load_set(input int s);
        for (int k = 0; k < 16; k++) in_mem[k] = (s == 0) ? 8'(9 - k) : 8'd1;
        for (int k = 0; k < 128; k++) w_mem[k] = (s == 0) ? 8'(k) : ((s == 1) ? 8'd1 : 8'd0);
        for (int k = 0; k < 16; k++) b_mem[k] = (s == 1) ? 8'd0 : 8'(k);
        compute_model();
        for (int k = 0; k < N_OUT; k++) got[k] = -1;
        nwr = 0;
        ndone = 0;
    endtask

    // Expected cycle-by-cycle behaviour for the cycle following the last edge.
    always @(negedge clk) begin
        if (checking) begin
            int c;
            bit eb, ed, ew;
            c  = cyc - run_start;
            eb = live && c >= 0 && c <= TOT;
            ed = live && c == TOT;
            ew = live && c >= 0 && c < TOT && (c % PER) == PER - 1;
            chk("busy", int'(busy), int'(eb));
            chk("done", int'(done), int'(ed));
            chk("out_we", int'(out_we), int'(ew));
            if (ew) begin
                chk("out_addr", int'(out_addr), c / PER);
                chk("out_data", int'(out_data), exp_out[c / PER]);
            end
            if (out_we) begin
                got[out_addr] = out_data;
                nwr++;
            end
            if (done) ndone++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_layer();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        run_start = cyc;
        live = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        load_set(1);
        #2 rst_n = 1'b0;
        #2;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst out_we", int'(out_we), 0);
        chk("rst in_addr", int'(in_addr), 0);
        chk("rst w_addr", int'(w_addr), 0);
        chk("rst b_addr", int'(b_addr), 0);
        chk("rst out_addr", int'(out_addr), 0);
        chk("rst out_data", int'(out_data), 0);
        wait_cycles(2);
        rst_n = 1'b1;
        checking = 1'b1;

        // Mixed data with saturation on neurons 1..9.
        load_set(0);
        chk("model out0", exp_out[0], 120);
        chk("model out1", exp_out[1], 255);
        run_layer();
        wait_cycles(TOT + 4);
        live = 1'b0;
        chk("A out0", got[0], 120);
        for (int k = 1; k < N_OUT; k++) chk("A sat", got[k], 255);
        chk("A writes", nwr, 10);
        chk("A dones", ndone, 1);

        // All ones: each neuron 10.
        load_set(1);
        run_layer();
        wait_cycles(TOT + 4);
        live = 1'b0;
        for (int k = 0; k < N_OUT; k++) chk("B out", got[k], 10);
        chk("B writes", nwr, 10);

        // Zero weights: bias passes through.
        load_set(2);
        run_layer();
        wait_cycles(TOT + 4);
        live = 1'b0;
        for (int k = 0; k < N_OUT; k++) chk("C out", got[k], k);

        // Reset mid-evaluation, then a clean rerun.
        load_set(1);
        run_layer();
        wait_cycles(50);
        rst_n = 1'b0;
        live = 1'b0;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst out_we", int'(out_we), 0);
        chk("midrst done", int'(done), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        chk("midrst dones", ndone, 0);
        load_set(1);
        run_layer();
        wait_cycles(TOT + 4);
        live = 1'b0;
        for (int k = 0; k < N_OUT; k++) chk("D out", got[k], 10);
        chk("D writes", nwr, 10);

        // Abort sampled 30 edges after start.
        load_set(1);
        run_layer();
        wait_cycles(29);
        abort = 1'b1;
        @(posedge clk);
        #1;
        live = 1'b0;
        abort = 1'b0;
        wait_cycles(10);
        chk("abort writes", nwr, 2);
        chk("abort out0", got[0], 10);
        chk("abort out1", got[1], 10);
        chk("abort busy", int'(busy), 0);
        wait_cycles(TOT);
        chk("abort dones", ndone, 0);

        // start held high through DONE: ignored while busy, a new run begins
        // from the IDLE cycle that follows DONE.
        load_set(0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        run_start = cyc;
        live = 1'b1;
        wait_cycles(TOT + 2);
        chk("E1 writes", nwr, 10);
        chk("E1 dones", ndone, 1);
        run_start = cyc;
        start = 1'b0;
        wait_cycles(TOT + 4);
        live = 1'b0;
        chk("E2 writes", nwr, 20);
        chk("E2 dones", ndone, 2);
        chk("E2 out0", got[0], 120);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
